// File: rtl/uart_frame_tx.sv
// Frame builder in front of a byte-level UART transmitter. Each frame is SYNC,
// then NBYTES payload bytes (byte 0 first), then the XOR checksum of the payload.
module uart_frame_tx #(
    parameter int          NBYTES = 4,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send,
    input  logic [8*NBYTES-1:0]   payload,
    input  logic                  tx_ready,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    function automatic logic [7:0] pick_byte(input logic [8*NBYTES-1:0] vec,
                                             input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == 4'(k)) begin
                b = vec[8*k +: 8];
            end
        end
        return b;
    endfunction

    state_t               state_r,      state_nxt_s;
    logic [8*NBYTES-1:0]  payload_r,    payload_nxt_s;
    logic [3:0]           cnt_r,        cnt_nxt_s;
    logic [7:0]           csum_r,       csum_nxt_s;
    logic [7:0]           tx_data_r,    tx_data_nxt_s;
    logic                 tx_start_r,   tx_start_nxt_s;
    logic                 busy_r,       busy_nxt_s;
    logic                 frame_done_r, frame_done_nxt_s;
    logic                 tx_ready_q_r;
    logic                 accept_s;

    // A byte is taken on the falling edge of tx_ready while the request is held;
    // the stop-pulse cycle keeps tx_ready high, so the byte lands one cycle later.
    assign accept_s = tx_start_r & tx_ready_q_r & ~tx_ready;

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s      = state_r;
        payload_nxt_s    = payload_r;
        cnt_nxt_s        = cnt_r;
        csum_nxt_s       = csum_r;
        tx_data_nxt_s    = tx_data_r;
        tx_start_nxt_s   = tx_start_r;
        busy_nxt_s       = busy_r;
        frame_done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (send) begin
                    payload_nxt_s  = payload;
                    csum_nxt_s     = 8'h00;
                    cnt_nxt_s      = 4'd0;
                    busy_nxt_s     = 1'b1;
                    tx_start_nxt_s = 1'b1;
                    tx_data_nxt_s  = SYNC;
                    state_nxt_s    = ST_HDR;
                end else begin
                    busy_nxt_s     = 1'b0;
                    tx_start_nxt_s = 1'b0;
                end
            end
            ST_HDR: begin
                if (accept_s) begin
                    tx_data_nxt_s = pick_byte(payload_r, 4'd0);
                    state_nxt_s   = ST_DATA;
                end else begin
                    state_nxt_s   = ST_HDR;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    csum_nxt_s = csum_r ^ tx_data_r;
                    if (cnt_r == LAST_IDX) begin
                        tx_data_nxt_s = csum_r ^ tx_data_r;
                        state_nxt_s   = ST_CSUM;
                    end else begin
                        cnt_nxt_s     = cnt_r + 4'd1;
                        tx_data_nxt_s = pick_byte(payload_r, cnt_r + 4'd1);
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    tx_start_nxt_s   = 1'b0;
                    busy_nxt_s       = 1'b0;
                    frame_done_nxt_s = 1'b1;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    state_nxt_s      = ST_CSUM;
                end
            end
            default: begin
                tx_start_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
                state_nxt_s    = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            payload_r    <= '0;
            cnt_r        <= 4'd0;
            csum_r       <= 8'h00;
            tx_data_r    <= 8'h00;
            tx_start_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            tx_ready_q_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            payload_r    <= payload_nxt_s;
            cnt_r        <= cnt_nxt_s;
            csum_r       <= csum_nxt_s;
            tx_data_r    <= tx_data_nxt_s;
            tx_start_r   <= tx_start_nxt_s;
            busy_r       <= busy_nxt_s;
            frame_done_r <= frame_done_nxt_s;
            tx_ready_q_r <= tx_ready;
        end
    end

    assign tx_start   = tx_start_r;
    assign tx_data    = tx_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Upstream feeder for the byte-level UART transmitter in the pong link.
- Captures a multi-byte game-state payload (paddle/ball positions, score) on request and builds a frame: SYNC byte, then the payload bytes LSB-byte first, then an XOR checksum byte.
- Feeds the frame one byte at a time through the transmitter's tx_start/tx_ready handshake.
- Sits between the game logic and the UART transmitter on the sending board.

Parameters:
- NBYTES, 4, number of payload bytes per frame; legal range 1..14.
- SYNC, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- send  in  1  frame request; sampled only in IDLE.
- payload  in  8*NBYTES  frame payload; byte k is payload[8k+7:8k] and is sent k-th.
- tx_ready  in  1  from the UART transmitter; high while it is idle, plus a 1-cycle pulse on the final stop-bit tick.
- tx_start  out  1  to the UART transmitter; request to send tx_data.
- tx_data  out  8  byte to transmit.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  1-cycle pulse when the checksum byte has been accepted.

Behaviour:
- Reset is asynchronous, active-low. It is the only reset.
- Reset values: state IDLE, tx_start=0, tx_data=0, busy=0, frame_done=0. Internal payload register, byte counter, checksum and tx_ready_q are all cleared.
- All outputs are registered or decoded from registered state. No combinational path from send or tx_ready to any output.
- tx_ready_q is tx_ready registered every cycle.
- Byte acceptance:
  - Accepted = tx_start high AND tx_ready_q=1 AND tx_ready=0, i.e. a falling edge of tx_ready while the request is held.
  - While tx_start is high, tx_data is held stable.
  - tx_start stays high through the transmitter's stop-pulse cycle (in that cycle the transmitter ignores tx_start). The byte is therefore taken in the next idle cycle and no byte is ever lost.
- State machine:
  - IDLE: busy=0, tx_start=0. If send=1: capture payload, clear checksum to 0, clear byte counter, set busy=1, load tx_data=SYNC, go to HDR.
  - HDR: tx_start=1. On acceptance: load tx_data=payload byte 0, go to DATA.
  - DATA: tx_start=1. On acceptance:
    - checksum ^= tx_data.
    - If counter==NBYTES-1: load tx_data = checksum ^ tx_data (final checksum), go to CSUM.
    - Else: counter+1, load tx_data=next payload byte.
  - CSUM: tx_start=1. On acceptance: tx_start=0, busy=0, frame_done=1 for one cycle, go to IDLE.
- tx_start drops in the cycle after acceptance only when leaving CSUM. Between bytes it stays high, because the transmitter is busy and tx_ready stays low until its stop pulse.
- Latency:
  - send to first tx_start: 1 cycle.
  - Frame length: NBYTES+2 bytes.
  - frame_done: 1 cycle after the checksum byte's acceptance edge.
- Boundary conditions:
  - send while busy: ignored, no queuing. The payload register is untouched mid-frame.
  - send held high continuously: a new frame starts in the cycle after frame_done (IDLE sees send=1).
  - Checksum is the XOR over the payload bytes only; SYNC is excluded.
  - NBYTES=1: DATA lasts one byte, then CSUM with checksum = byte 0.
  - Reset mid-frame: immediate return to IDLE, tx_start=0, no frame_done. A partial frame on the wire is the receiver's problem; it resyncs on SYNC.
  - tx_ready stuck low: the block waits indefinitely in HDR/DATA/CSUM with tx_start high. There is no timeout.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, no send for 20 cycles -> tx_start=0, busy=0, frame_done=0, tx_data=0 throughout.
- Nominal frame (NBYTES=4, payload=32'h44332211, real uart_tx with 16x tick) -> decoded tx line bytes A5,11,22,33,44,44. busy high throughout. Exactly one frame_done pulse, after the sixth byte's acceptance.
- Stop-pulse handshake: tx_ready model gives a 1-cycle pulse, then idle-high for 1 cycle, then low -> each byte accepted exactly once. tx_data unchanged between pulse and acceptance. No byte duplicated or skipped.
- send during frame: send pulse with payload=32'hDEADBEEF while the 3rd byte is in flight -> the current frame still ends 33,44,44; no second frame starts.
- Back-to-back frames: send held high, payload=32'h000000FF -> frames A5,FF,00,00,00,FF repeat contiguously. Each new HDR tx_start rises 1 cycle after frame_done.
- Reset mid-frame: assert reset during DATA byte 2 -> tx_start=0, busy=0 asynchronously. After release and send with payload=32'h01020304 -> A5,04,03,02,01,04.
